// File: rtl/blur_pkg.sv
// Shared types and helpers for the blur frame sequencer.
// Kernel-select codes, FSM states and kernel size lookup.
package blur_pkg;

  localparam logic [2:0] KSEL_1X1 = 3'd0;
  localparam logic [2:0] KSEL_3X3 = 3'd1;
  localparam logic [2:0] KSEL_5X5 = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic logic [2:0] ksel_to_size(input logic [2:0] ksel);
    case (ksel)
      KSEL_3X3: return 3'd3;
      KSEL_5X5: return 3'd5;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/blur_frame_sequencer_if.sv
// Pixel, filter and output bundle of the blur frame sequencer.
// slave = sequencer side, master = source/filter/sink side.
interface blur_frame_sequencer_if #(
  parameter int DATA_WIDTH = 12
);
  logic [2:0]            freq_req;
  logic                  pix_valid;
  logic                  pix_sof;
  logic [DATA_WIDTH-1:0] pix_data;
  logic [2:0]            filt_freq_flag;
  logic                  filt_ready_in;
  logic [DATA_WIDTH-1:0] filt_data_in;
  logic                  filt_ready_out;
  logic [DATA_WIDTH-1:0] filt_data_out;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_border;
  logic                  frame_done;
  logic [2:0]            active_flag;
  logic                  err_gap;
  logic                  err_sof;
  logic                  err_clr;

  modport slave (
    input  freq_req, pix_valid, pix_sof, pix_data,
    input  filt_ready_out, filt_data_out, err_clr,
    output filt_freq_flag, filt_ready_in, filt_data_in,
    output out_valid, out_data, out_border, frame_done,
    output active_flag, err_gap, err_sof
  );

  modport master (
    output freq_req, pix_valid, pix_sof, pix_data,
    output filt_ready_out, filt_data_out, err_clr,
    input  filt_freq_flag, filt_ready_in, filt_data_in,
    input  out_valid, out_data, out_border, frame_done,
    input  active_flag, err_gap, err_sof
  );
endinterface

// File: rtl/blur_pixel_counter.sv
// Raster x/y counter holding the coordinate of the next pixel.
// Load marks (0,0) as consumed; advance steps in raster order.
module blur_pixel_counter #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_adv,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_end;
  logic          w_y_end;

  assign w_x_end = (r_x == XW'(WIDTH - 1));
  assign w_y_end = (r_y == YW'(HEIGHT - 1));
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_last  = w_x_end && w_y_end;

  // Raster position update; load wins over advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= XW'(1);
      r_y <= '0;
    end else if (i_adv) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end
endmodule

// File: rtl/blur_frame_sequencer.sv
// Frame sequencer in front of the blur filter: kernel latch,
// input gating, output alignment, halo substitution, errors.
module blur_frame_sequencer
  import blur_pkg::*;
#(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int DATA_WIDTH  = 12,
  parameter int BORDER_MODE = 1
) (
  input logic clk,
  input logic reset,
  blur_frame_sequencer_if.slave bus
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  state_t                r_state;
  logic                  r_drain;
  logic [2:0]            r_active_flag;
  logic                  r_ready_in;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic [DATA_WIDTH-1:0] r_raw_d2;
  logic                  r_first_d1;
  logic                  r_first_d2;
  logic [2:0]            r_k_d2;
  logic                  r_err_gap;
  logic                  r_err_sof;

  logic                  w_sof_take;
  logic                  w_run_adv;
  logic                  w_gap;
  logic                  w_early;
  logic [2:0]            w_req;
  logic [XW-1:0]         w_in_x;
  logic [YW-1:0]         w_in_y;
  logic                  w_in_last;
  logic [XW-1:0]         w_cnt_x;
  logic [YW-1:0]         w_cnt_y;
  logic                  w_cnt_last;
  logic                  w_border;
  logic                  w_unused_in;

  assign w_sof_take = bus.pix_valid && bus.pix_sof &&
                      (r_state == IDLE || r_state == RUN);
  assign w_early    = bus.pix_valid && bus.pix_sof && r_state == RUN;
  assign w_run_adv  = bus.pix_valid && !bus.pix_sof && r_state == RUN;
  assign w_gap      = !bus.pix_valid && r_state == RUN;
  assign w_req      = (bus.freq_req > KSEL_5X5) ? KSEL_1X1 : bus.freq_req;
  assign w_unused_in = ^{w_in_x, w_in_y};

  blur_pixel_counter #(
    .WIDTH (IMG_WIDTH),
    .HEIGHT(IMG_HEIGHT)
  ) u_in_cnt (
    .clk   (clk),
    .reset (reset),
    .i_load(w_sof_take),
    .i_adv (w_run_adv),
    .o_x   (w_in_x),
    .o_y   (w_in_y),
    .o_last(w_in_last)
  );

  blur_pixel_counter #(
    .WIDTH (IMG_WIDTH),
    .HEIGHT(IMG_HEIGHT)
  ) u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .i_load(bus.filt_ready_out && r_first_d2),
    .i_adv (bus.filt_ready_out && !r_first_d2),
    .o_x   (w_cnt_x),
    .o_y   (w_cnt_y),
    .o_last(w_cnt_last)
  );

  // Frame FSM: kernel latch on sof, gap abort, drain after last pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_drain       <= 1'b0;
      r_active_flag <= KSEL_1X1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_sof_take) begin
            r_state       <= RUN;
            r_active_flag <= w_req;
          end
        end
        RUN: begin
          if (w_sof_take) begin
            r_active_flag <= w_req;
          end else if (!bus.pix_valid) begin
            r_state <= IDLE;
          end else if (w_in_last) begin
            r_state <= DRAIN;
            r_drain <= 1'b0;
          end
        end
        DRAIN: begin
          if (r_drain) r_state <= IDLE;
          r_drain <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Filter input register plus the alignment pipe to the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready_in <= 1'b0;
      r_data_in  <= '0;
      r_raw_d2   <= '0;
      r_first_d1 <= 1'b0;
      r_first_d2 <= 1'b0;
      r_k_d2     <= 3'd1;
    end else begin
      r_ready_in <= w_sof_take || w_run_adv;
      r_data_in  <= bus.pix_data;
      r_raw_d2   <= r_data_in;
      r_first_d1 <= w_sof_take;
      r_first_d2 <= r_first_d1;
      r_k_d2     <= ksel_to_size(r_active_flag);
    end
  end

  // Sticky stream errors; a new event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_gap <= 1'b0;
      r_err_sof <= 1'b0;
    end else begin
      if (w_gap) r_err_gap <= 1'b1;
      else if (bus.err_clr) r_err_gap <= 1'b0;
      if (w_early) r_err_sof <= 1'b1;
      else if (bus.err_clr) r_err_sof <= 1'b0;
    end
  end

  // Halo test on the coordinate of the pixel leaving the filter.
  always_comb begin
    w_border = 1'b0;
    if (!r_first_d2) begin
      w_border = (int'(w_cnt_x) < int'(r_k_d2) - 1) ||
                 (int'(w_cnt_y) < int'(r_k_d2) - 1);
    end else begin
      w_border = (int'(r_k_d2) > 1);
    end
  end

  assign bus.filt_freq_flag = r_active_flag;
  assign bus.filt_ready_in  = r_ready_in;
  assign bus.filt_data_in   = r_data_in;
  assign bus.active_flag    = r_active_flag;
  assign bus.err_gap        = r_err_gap;
  assign bus.err_sof        = r_err_sof;
  assign bus.out_valid      = bus.filt_ready_out;
  assign bus.out_border     = bus.filt_ready_out && w_border;
  assign bus.frame_done     = bus.filt_ready_out && !r_first_d2 &&
                              w_cnt_last;
  assign bus.out_data       = !bus.filt_ready_out ? '0 :
                              !w_border ? bus.filt_data_out :
                              (BORDER_MODE != 0) ? r_raw_d2 : '0;
endmodule

// File: tb/tb_blur_frame_sequencer.sv
// Directed bench for blur_frame_sequencer on a 16x8 frame.
// A 1-cycle filter model feeds a queue-based output scoreboard.
module tb_blur_frame_sequencer;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int DW = 12;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          b;
    logic          f;
  } exp_t;

  logic clk;
  logic reset;
  blur_frame_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  blur_frame_sequencer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_WIDTH (DW),
    .BORDER_MODE(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Filter model: one-cycle latency, identity for 1x1, xor otherwise.
  always @(posedge clk) begin
    if (reset) begin
      bus.filt_ready_out <= 1'b0;
      bus.filt_data_out  <= '0;
    end else begin
      bus.filt_ready_out <= bus.filt_ready_in;
      bus.filt_data_out  <= (bus.filt_freq_flag == 3'd0) ?
                            bus.filt_data_in :
                            bus.filt_data_in ^ 12'h3C3;
    end
  end

  exp_t q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   n_done   = 0;
  int   mx, my;
  int   mflag;
  bit   in_frame = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("out_data", {20'd0, bus.out_data}, {20'd0, e.d});
        chk("out_border", {31'd0, bus.out_border}, {31'd0, e.b});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, e.f});
      end
      if (bus.frame_done === 1'b1) n_done++;
    end else begin
      chk("done_no_valid", {31'd0, bus.frame_done}, 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic send(input bit sof, input logic [DW-1:0] d);
    exp_t e;
    int   k;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_data  = d;
    if (sof) begin
      mflag    = (bus.freq_req > 3'd2) ? 0 : int'(bus.freq_req);
      mx       = 0;
      my       = 0;
      in_frame = 1;
    end
    if (in_frame) begin
      k   = 1 + 2 * mflag;
      e.b = (mx < k - 1) || (my < k - 1);
      e.d = e.b ? d : (mflag == 0 ? d : d ^ 12'h3C3);
      e.f = (mx == W - 1) && (my == H - 1);
      q.push_back(e);
      if (e.f) begin
        in_frame = 0;
      end else begin
        mx++;
        if (mx == W) begin
          mx = 0;
          my++;
        end
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      in_frame      = 0;
      tick();
    end
  endtask

  task automatic run_px(input int n, input bit first_sof, input bit cst);
    for (int i = 0; i < n; i++) begin
      send(first_sof && i == 0, cst ? 12'hFFF : DW'($urandom));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rin"},  {31'd0, bus.filt_ready_in}, 32'd0);
    chk({tag, "_din"},  {20'd0, bus.filt_data_in}, 32'd0);
    chk({tag, "_ff"},   {29'd0, bus.filt_freq_flag}, 32'd0);
    chk({tag, "_ov"},   {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_od"},   {20'd0, bus.out_data}, 32'd0);
    chk({tag, "_ob"},   {31'd0, bus.out_border}, 32'd0);
    chk({tag, "_fd"},   {31'd0, bus.frame_done}, 32'd0);
    chk({tag, "_af"},   {29'd0, bus.active_flag}, 32'd0);
    chk({tag, "_eg"},   {31'd0, bus.err_gap}, 32'd0);
    chk({tag, "_es"},   {31'd0, bus.err_sof}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.freq_req  = 3'd0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = '0;
    bus.err_clr   = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk_reset_outs("rst");
    reset = 1'b0;
    tick();

    // 1x1 frame: pass-through, latency 2, one frame_done.
    bus.freq_req = 3'd0;
    n_done = 0;
    send(1'b1, 12'h123);
    chk("lat_rin", {31'd0, bus.filt_ready_in}, 32'd1);
    chk("lat_ov0", {31'd0, bus.out_valid}, 32'd0);
    send(1'b0, 12'h456);
    chk("lat_ov1", {31'd0, bus.out_valid}, 32'd1);
    run_px(N - 2, 1'b0, 1'b0);
    idle(4);
    chk("t1_done", n_done, 32'd1);
    chk("t1_q", q.size(), 32'd0);

    // 5x5 constant frame: halo rows/cols use raw pixel.
    bus.freq_req = 3'd2;
    n_done = 0;
    run_px(N, 1'b1, 1'b1);
    chk("t2_af", {29'd0, bus.active_flag}, 32'd2);
    idle(4);
    chk("t2_done", n_done, 32'd1);

    // Kernel request change mid-frame holds until next sof.
    bus.freq_req = 3'd1;
    run_px(20, 1'b1, 1'b0);
    bus.freq_req = 3'd2;
    send(1'b0, 12'h0AB);
    chk("t3_ff_hold", {29'd0, bus.filt_freq_flag}, 32'd1);
    run_px(N - 21, 1'b0, 1'b0);
    chk("t3_af_hold", {29'd0, bus.active_flag}, 32'd1);
    idle(4);
    n_done = 0;
    send(1'b1, 12'h777);
    chk("t3_ff_new", {29'd0, bus.filt_freq_flag}, 32'd2);

    // Gap at (5,3): err_gap, input strobe drops, frame abandoned.
    run_px(52, 1'b0, 1'b0);
    idle(1);
    chk("gap_err", {31'd0, bus.err_gap}, 32'd1);
    chk("gap_rin", {31'd0, bus.filt_ready_in}, 32'd0);
    run_px(5, 1'b0, 1'b0);
    idle(4);
    chk("gap_nodone", n_done, 32'd0);
    chk("gap_q", q.size(), 32'd0);

    // Early sof at (10,3): restart with re-latched kernel.
    bus.freq_req = 3'd1;
    n_done = 0;
    run_px(58, 1'b1, 1'b0);
    bus.freq_req = 3'd2;
    send(1'b1, 12'h5A5);
    chk("sof_err", {31'd0, bus.err_sof}, 32'd1);
    chk("sof_af", {29'd0, bus.active_flag}, 32'd2);
    run_px(N - 1, 1'b0, 1'b0);
    idle(4);
    chk("sof_done", n_done, 32'd1);
    chk("gap_sticky", {31'd0, bus.err_gap}, 32'd1);

    // err_clr alone clears; with a same-cycle gap the error wins.
    bus.err_clr = 1'b1;
    idle(1);
    bus.err_clr = 1'b0;
    chk("clr_gap", {31'd0, bus.err_gap}, 32'd0);
    chk("clr_sof", {31'd0, bus.err_sof}, 32'd0);
    bus.freq_req = 3'd0;
    run_px(10, 1'b1, 1'b0);
    bus.err_clr = 1'b1;
    idle(1);
    bus.err_clr = 1'b0;
    chk("clr_vs_gap", {31'd0, bus.err_gap}, 32'd1);
    idle(3);

    // Reset mid-frame aborts everything; then a clean frame.
    bus.freq_req = 3'd1;
    n_done = 0;
    run_px(30, 1'b1, 1'b0);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    reset         = 1'b1;
    q.delete();
    in_frame = 0;
    tick();
    chk_reset_outs("mid_rst");
    reset = 1'b0;
    tick();
    bus.freq_req = 3'd5;
    run_px(N, 1'b1, 1'b0);
    chk("map_af", {29'd0, bus.active_flag}, 32'd0);
    idle(4);
    chk("rst_done", n_done, 32'd1);
    chk("rst_q", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
